vend_txn_controller: RTL and testbench



---
 rtl/vend_txn_controller.sv | 172 +++++++++++++++++
 tb/tb_vend_txn_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_txn_controller.sv
// ----------------------------------------------------------------------------
// vend_txn_controller
//
// Transaction controller for the vending machine. Two coin slots share one
// credit accumulator through round-robin arbitration and a req/ack handshake.
// Once the credit reaches the price, the product is released and any excess is
// returned as 5-unit change pulses. Cancel or an inactivity timeout in COLLECT
// refunds the whole credit as change pulses.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   coin_req[1:0] per-slot request, held with coin_type stable until acked
//   coin_type[1:0] per-slot coin value: 0 = 5 units (1 credit), 1 = 10 units
//   cancel        level request to refund the current credit
//   coin_ack[1:0] registered one-hot, one-cycle acceptance pulse per slot
//   dispense      one-cycle product release pulse
//   change_pulse  one-cycle pulse per 5 units returned
//   busy          high while dispensing or returning change
//   credit        accumulated credit in 5-unit units
//
// Handshake: a slot's request is accepted at the edge where coin_ack[n] rises;
// the credit increment is visible in the same cycle as the ack. The requester
// drops or changes its request at the edge after it sees the ack. No grant is
// made while coin_ack is high, so a request still held during the ack cycle is
// never accepted twice.
//
// Output pulses (coin_ack, dispense, change_pulse) are registered at the edge
// that applies their credit effect, so each pulse appears together with the
// updated credit value.
// ----------------------------------------------------------------------------
module vend_txn_controller #(
    parameter int PRICE_U  = 3,
    parameter int TIMEOUT  = 16,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin_req,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic [1:0]          coin_ack,
    output logic                dispense,
    output logic                change_pulse,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    localparam int                  TW      = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_U);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);
    localparam logic [TW-1:0]       T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]       T_ONE   = TW'(1);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                last_slot;     // slot granted most recently
    logic [TW-1:0]       tcnt;
    logic [TW-1:0]       tcnt_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W-1:0] credit_add;
    logic [CREDIT_W-1:0] coin_val;
    logic [1:0]          gnt;
    logic                can_grant;
    logic                dispense_nxt;
    logic                change_nxt;

    // Arbitration: a held request is ignored during its own ack cycle, and
    // cancel suppresses grants so a refund never races a new coin.
    always_comb begin
        can_grant = ((state == S_IDLE) || (state == S_COLLECT)) &&
                    !cancel && (coin_ack == 2'b00);
        gnt = 2'b00;
        if (can_grant) begin
            case (coin_req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_slot ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        coin_val = '0;
        if (gnt[0]) begin
            coin_val = coin_type[0] ? TWO_C : ONE_C;
        end else if (gnt[1]) begin
            coin_val = coin_type[1] ? TWO_C : ONE_C;
        end
        credit_add = credit + coin_val;
    end

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        tcnt_nxt     = tcnt;
        dispense_nxt = 1'b0;
        change_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                tcnt_nxt = '0;
                if (gnt != 2'b00) begin
                    credit_nxt = credit_add;
                    state_nxt  = (credit_add >= PRICE_C) ? S_DISPENSE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    state_nxt = S_CHANGE;
                    tcnt_nxt  = '0;
                end else if (gnt != 2'b00) begin
                    credit_nxt = credit_add;
                    tcnt_nxt   = '0;
                    if (credit_add >= PRICE_C) begin
                        state_nxt = S_DISPENSE;
                    end
                end else if (tcnt == T_LAST) begin
                    state_nxt = S_CHANGE;
                    tcnt_nxt  = '0;
                end else begin
                    tcnt_nxt = tcnt + T_ONE;
                end
            end
            S_DISPENSE: begin
                dispense_nxt = 1'b1;
                credit_nxt   = credit - PRICE_C;
                state_nxt    = (credit == PRICE_C) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE: begin
                // Credit is always non-zero on entry; the zero guard only keeps
                // the counter from wrapping if that ever fails to hold.
                change_nxt = (credit != '0);
                credit_nxt = (credit != '0) ? (credit - ONE_C) : '0;
                if (credit <= ONE_C) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            credit       <= '0;
            tcnt         <= '0;
            last_slot    <= 1'b1;   // makes slot 0 the first winner
            coin_ack     <= 2'b00;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            tcnt         <= tcnt_nxt;
            coin_ack     <= gnt;
            dispense     <= dispense_nxt;
            change_pulse <= change_nxt;
            busy         <= (state_nxt == S_DISPENSE) || (state_nxt == S_CHANGE);
            if (gnt != 2'b00) begin
                last_slot <= gnt[1];
            end
        end
    end

endmodule

// File: tb/tb_vend_txn_controller.sv
// ----------------------------------------------------------------------------
// tb_vend_txn_controller
//
// Directed scenarios followed by randomized coin/cancel traffic. The reference
// model keeps the credit as an integer plus a queue of actuator actions still
// owed (dispense, change); the machine counts as busy while that queue is not
// empty. Every cycle all outputs are compared against the model.
// ----------------------------------------------------------------------------
module tb_vend_txn_controller;

    localparam int PRICE_U  = 3;
    localparam int TIMEOUT  = 16;
    localparam int CREDIT_W = 4;

    localparam int ACT_DISP = 1;
    localparam int ACT_CHG  = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          coin_req;
    logic [1:0]          coin_type;
    logic                cancel;
    logic [1:0]          coin_ack;
    logic                dispense;
    logic                change_pulse;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    vend_txn_controller #(
        .PRICE_U (PRICE_U),
        .TIMEOUT (TIMEOUT),
        .CREDIT_W(CREDIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_req    (coin_req),
        .coin_type   (coin_type),
        .cancel      (cancel),
        .coin_ack    (coin_ack),
        .dispense    (dispense),
        .change_pulse(change_pulse),
        .busy        (busy),
        .credit      (credit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    int         m_credit;
    logic [1:0] m_ack;
    int         m_last;
    int         m_idle;
    int         act_q[$];
    logic       e_disp;
    logic       e_chg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_refund(input int n);
        for (int i = 0; i < n; i++) act_q.push_back(ACT_CHG);
    endtask

    // Predicts what the coming clock edge produces from the present inputs.
    task automatic model_edge();
        logic [1:0] nack;
        int         slot;
        int         act;
        nack   = 2'b00;
        e_disp = 1'b0;
        e_chg  = 1'b0;
        if (rst) begin
            m_credit = 0;
            act_q.delete();
            m_last = 1;
            m_idle = 0;
        end else if (act_q.size() > 0) begin
            act = act_q.pop_front();
            if (act == ACT_DISP) begin
                e_disp   = 1'b1;
                m_credit = m_credit - PRICE_U;
            end else begin
                e_chg    = 1'b1;
                m_credit = m_credit - 1;
            end
        end else if (cancel && m_credit > 0) begin
            push_refund(m_credit);
            m_idle = 0;
        end else if (!cancel && m_ack == 2'b00 && coin_req != 2'b00) begin
            if (coin_req == 2'b11) slot = (m_last == 0) ? 1 : 0;
            else                   slot = coin_req[1] ? 1 : 0;
            m_last     = slot;
            nack[slot] = 1'b1;
            m_credit   = m_credit + (coin_type[slot] ? 2 : 1);
            m_idle     = 0;
            if (m_credit >= PRICE_U) begin
                act_q.push_back(ACT_DISP);
                push_refund(m_credit - PRICE_U);
            end
        end else if (m_credit > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                push_refund(m_credit);
                m_idle = 0;
            end
        end
        m_ack = nack;
    endtask

    // driver: one clock, full output check, then requesters drop acked coins
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("coin_ack",     32'(coin_ack),     32'(m_ack));
        chk("dispense",     32'(dispense),     32'(e_disp));
        chk("change_pulse", 32'(change_pulse), 32'(e_chg));
        chk("credit",       32'(credit),       32'(m_credit));
        chk("busy",         32'(busy),         32'(act_q.size() > 0));
        for (int n = 0; n < 2; n++) begin
            if (m_ack[n]) coin_req[n] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        coin_req  = 2'b00;
        coin_type = 2'b00;
        cancel    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int slot, input int budget, input string tag);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (coin_ack[slot]) begin
                got = 1;
                break;
            end
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    int nchg;
    int ndisp;
    int quiet;

    initial begin
        m_credit = 0;
        m_ack    = 2'b00;
        m_last   = 1;
        m_idle   = 0;
        e_disp   = 1'b0;
        e_chg    = 1'b0;

        // reset with both slots requesting
        rst       = 1'b1;
        coin_req  = 2'b11;
        coin_type = 2'b00;
        cancel    = 1'b0;
        step();
        step();
        chk("reset_ack",    32'(coin_ack), 32'd0);
        chk("reset_credit", 32'(credit),   32'd0);
        chk("reset_busy",   32'(busy),     32'd0);
        rst = 1'b0;
        step();
        chk("first_grant_slot0", 32'(coin_ack), 32'd1);

        // exact price: three 5-unit coins on slot 0
        do_reset();
        for (int k = 1; k <= PRICE_U; k++) begin
            coin_req[0]  = 1'b1;
            coin_type[0] = 1'b0;
            wait_ack(0, 4, "exact_ack");
            chk("exact_credit", 32'(credit), 32'(k));
        end
        step();
        chk("exact_dispense", 32'(dispense), 32'd1);
        chk("exact_credit0",  32'(credit),   32'd0);
        nchg = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            nchg += 32'(change_pulse);
        end
        chk("exact_no_change", 32'(nchg), 32'd0);

        // overshoot and arbitration: both slots hold 10-unit coins
        do_reset();
        coin_req  = 2'b11;
        coin_type = 2'b11;
        wait_ack(0, 4, "over_ack0");
        chk("over_credit2", 32'(credit), 32'd2);
        step();
        chk("over_gap", 32'(coin_ack), 32'd0);
        step();
        chk("over_ack1",    32'(coin_ack), 32'd2);
        chk("over_credit4", 32'(credit),   32'd4);
        step();
        chk("over_dispense", 32'(dispense), 32'd1);
        step();
        chk("over_change",  32'(change_pulse), 32'd1);
        chk("over_credit0", 32'(credit),       32'd0);
        step();
        chk("over_change_end", 32'(change_pulse), 32'd0);

        // cancel refund while slot 0 requests
        do_reset();
        coin_req[1]  = 1'b1;
        coin_type[1] = 1'b1;
        wait_ack(1, 4, "cancel_coin");
        chk("cancel_credit2", 32'(credit), 32'd2);
        cancel       = 1'b1;
        coin_req[0]  = 1'b1;
        coin_type[0] = 1'b0;
        step();
        chk("cancel_no_ack", 32'(coin_ack), 32'd0);
        cancel = 1'b0;
        nchg  = 0;
        ndisp = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            nchg  += 32'(change_pulse);
            ndisp += 32'(dispense);
            chk("busy_no_ack", 32'(coin_ack), 32'd0);
        end
        chk("cancel_pulses",  32'(nchg),  32'd2);
        chk("cancel_no_disp", 32'(ndisp), 32'd0);
        step();
        chk("cancel_then_grant", 32'(coin_ack), 32'd1);

        // inactivity timeout after one 5-unit coin
        do_reset();
        coin_req[0]  = 1'b1;
        coin_type[0] = 1'b0;
        wait_ack(0, 4, "tmo_coin");
        nchg  = 0;
        ndisp = 0;
        for (int i = 0; i < TIMEOUT + 3; i++) begin
            step();
            nchg  += 32'(change_pulse);
            ndisp += 32'(dispense);
        end
        chk("tmo_pulses",  32'(nchg),   32'd1);
        chk("tmo_no_disp", 32'(ndisp),  32'd0);
        chk("tmo_credit0", 32'(credit), 32'd0);
        chk("tmo_idle",    32'(busy),   32'd0);

        // reset during refund with credit 1, slot 0 pending
        do_reset();
        coin_req[1]  = 1'b1;
        coin_type[1] = 1'b1;
        wait_ack(1, 4, "mid_coin");
        cancel = 1'b1;
        step();
        cancel      = 1'b0;
        coin_req[0] = 1'b1;
        step();
        chk("mid_credit1", 32'(credit), 32'd1);
        chk("mid_busy",    32'(busy),   32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_credit", 32'(credit),       32'd0);
        chk("mid_rst_change", 32'(change_pulse), 32'd0);
        rst         = 1'b0;
        coin_req[0] = 1'b0;
        step();
        chk("mid_after_change", 32'(change_pulse), 32'd0);

        // randomized traffic, with quiet stretches so timeouts occur
        do_reset();
        quiet = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) quiet = ($urandom_range(0, 2) == 0) ? 1 : 0;
            for (int n = 0; n < 2; n++) begin
                if (!coin_req[n]) begin
                    if ($urandom_range(0, quiet ? 60 : 3) == 0) begin
                        coin_req[n]  = 1'b1;
                        coin_type[n] = 1'($urandom_range(0, 1));
                    end
                end
            end
            cancel = ($urandom_range(0, 24) == 0);
            rst    = ($urandom_range(0, 599) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
